// File: rtl/digest_word_serializer.sv
// Streams a snapshot of a 256-bit SHA-256 digest out as WORD_W-bit words, most significant word first.
// Optional DIGEST_SER_BYTESWAP_EN: byte-reverse each output word (little-endian within the word).
module digest_word_serializer #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [255:0]      digest,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              word_last,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int NUM_WORDS = 256 / WORD_W;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [255:0]     snap, snap_nx;
    logic             done_nx, overrun_nx;

    function automatic logic [WORD_W-1:0] pick_word(input logic [255:0] s, input logic [IDX_W-1:0] i);
        logic [WORD_W-1:0] w;
        logic [WORD_W-1:0] r;
        w = s[255 - int'(i) * WORD_W -: WORD_W];
`ifdef DIGEST_SER_BYTESWAP_EN
        for (int b = 0; b < WORD_W / 8; b++) begin
            r[b*8 +: 8] = w[WORD_W-8-b*8 +: 8];
        end
`else
        r = w;
`endif
        return r;
    endfunction

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        snap_nx    = snap;
        done_nx    = 1'b0;
        overrun_nx = overrun;
        case (state)
            IDLE: begin
                if (start) begin
                    snap_nx  = digest;
                    idx_nx   = '0;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (start) overrun_nx = 1'b1;
                if (word_valid && word_ready) begin
                    if (idx == LAST_IDX) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            snap       <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            word_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            snap       <= snap_nx;
            word_valid <= (state_nx == SEND);
            busy       <= (state_nx == SEND);
            word_last  <= (state_nx == SEND) && (idx_nx == LAST_IDX);
            word_out   <= (state_nx == SEND) ? pick_word(snap_nx, idx_nx) : '0;
            done       <= done_nx;
            overrun    <= overrun_nx;
        end
    end

endmodule

// File: tb/tb_digest_word_serializer.sv
// Directed bench for digest_word_serializer (WORD_W=32), honours DIGEST_SER_BYTESWAP_EN.
module tb_digest_word_serializer;

    logic         clk = 1'b0;
    logic         reset, start, word_ready;
    logic [255:0] digest;
    logic [31:0]  word_out;
    logic         word_valid, word_last, busy, done, overrun;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        ready;
        logic [31:0] word;
        logic        last;
    } vec_t;

    vec_t        tbl[8];
    logic [31:0] dig2_w[8];

    localparam logic [255:0] DIG_ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_2 =
        256'he9b5b33f_0123abcd_4567ef01_89abcdef_13579bdf_2468ace0_c0ffee11_f7e84b8f;

    digest_word_serializer #(.WORD_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .digest(digest),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .word_last(word_last), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ew(input logic [31:0] w);
`ifdef DIGEST_SER_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string nm, input logic exp_ovr);
        chk({nm, "_valid"}, 64'(word_valid), 64'd0);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_last"}, 64'(word_last), 64'd0);
        chk({nm, "_wout"}, 64'(word_out), 64'd0);
        chk({nm, "_ovr"}, 64'(overrun), 64'(exp_ovr));
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'hba7816bf, 1'b0};
        tbl[1] = '{1'b1, 32'h8f01cfea, 1'b0};
        tbl[2] = '{1'b1, 32'h414140de, 1'b0};
        tbl[3] = '{1'b1, 32'h5dae2223, 1'b0};
        tbl[4] = '{1'b1, 32'hb00361a3, 1'b0};
        tbl[5] = '{1'b1, 32'h96177a9c, 1'b0};
        tbl[6] = '{1'b1, 32'hb410ff61, 1'b0};
        tbl[7] = '{1'b1, 32'hf20015ad, 1'b1};
        dig2_w = '{32'he9b5b33f, 32'h0123abcd, 32'h4567ef01, 32'h89abcdef,
                   32'h13579bdf, 32'h2468ace0, 32'hc0ffee11, 32'hf7e84b8f};

        reset = 1'b1; start = 1'b0; word_ready = 1'b0; digest = '0;
        tick(); tick();
        reset = 1'b0;
        chk_idle_outputs("rst", 1'b0);
        chk("rst_done", 64'(done), 64'd0);

        // ready ignored in IDLE
        word_ready = 1'b1;
        tick();
        chk_idle_outputs("idle_rdy", 1'b0);

        // Plain transfer driven from the table
        digest = DIG_ABC; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            word_ready = tbl[i].ready;
            chk($sformatf("t1_valid%0d", i), 64'(word_valid), 64'd1);
            chk($sformatf("t1_busy%0d", i), 64'(busy), 64'd1);
            chk($sformatf("t1_word%0d", i), 64'(word_out), 64'(ew(tbl[i].word)));
            chk($sformatf("t1_last%0d", i), 64'(word_last), 64'(tbl[i].last));
            chk($sformatf("t1_done%0d", i), 64'(done), 64'd0);
            tick();
        end
        chk("t1_done_pulse", 64'(done), 64'd1);
        chk_idle_outputs("t1_end", 1'b0);
        tick();
        chk("t1_done_drop", 64'(done), 64'd0);

        // Random stalls: model tracks the index the DUT must present
        begin
            int m_idx = 0;
            int cyc = 0;
            int done_seen = 0;
            word_ready = 1'b0; start = 1'b1;
            tick();
            start = 1'b0;
            while (m_idx < 8 && cyc < 300) begin
                word_ready = 1'($urandom_range(0, 1));
                chk("st_valid", 64'(word_valid), 64'd1);
                chk("st_word", 64'(word_out), 64'(ew(tbl[m_idx].word)));
                chk("st_last", 64'(word_last), 64'(m_idx == 7));
                if (done) done_seen++;
                if (word_ready) m_idx++;
                cyc++;
                tick();
            end
            chk("st_timeout", 64'(m_idx), 64'd8);
            chk("st_done_early", 64'(done_seen), 64'd0);
            chk("st_done", 64'(done), 64'd1);
            chk("st_valid_end", 64'(word_valid), 64'd0);
        end

        // Snapshot isolation, then back-to-back start at the earliest edge
        word_ready = 1'b1; digest = DIG_ABC; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) digest = DIG_2;
            chk($sformatf("snap_word%0d", i), 64'(word_out), 64'(ew(tbl[i].word)));
            tick();
        end
        chk("snap_done", 64'(done), 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("dig2_word%0d", i), 64'(word_out), 64'(ew(dig2_w[i])));
            tick();
        end
        chk("dig2_done", 64'(done), 64'd1);
        tick();

        // start while busy: at word 3 and on the last beat
        digest = DIG_ABC; start = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            start = (i == 3 || i == 7);
            chk($sformatf("ovr_word%0d", i), 64'(word_out), 64'(ew(tbl[i].word)));
            chk($sformatf("ovr_last%0d", i), 64'(word_last), 64'(i == 7));
            tick();
        end
        start = 1'b0;
        chk("ovr_done", 64'(done), 64'd1);
        chk_idle_outputs("ovr_end", 1'b1);
        tick();
        chk_idle_outputs("ovr_nostart", 1'b1);
        chk("ovr_done_drop", 64'(done), 64'd0);

        // Reset mid-transfer at idx 4 while stalled
        start = 1'b1; word_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("mid_word4", 64'(word_out), 64'(ew(tbl[4].word)));
        word_ready = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle_outputs("mid_rst", 1'b0);
        chk("mid_rst_done", 64'(done), 64'd0);
        tick();
        chk_idle_outputs("mid_rst_hold", 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_valid", 64'(word_valid), 64'd1);
        chk("restart_word0", 64'(word_out), 64'(ew(tbl[0].word)));
        chk("restart_last", 64'(word_last), 64'd0);
        tick();
        chk("restart_stall", 64'(word_out), 64'(ew(tbl[0].word)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digest_word_serializer.md
# digest_word_serializer

Reads a 256-bit SHA-256 message digest from the message digest register and streams it out as fixed-width words over a valid/ready handshake. Most significant word first: for WORD_W=32 the words are H0..H7. The block captures a snapshot of the digest on a start pulse, so the digest register may update again while the transfer is in progress. It connects the digest register to the downstream host/bus interface.

## Interface
- WORD_W, default 32: output word width. Legal values are 8, 16, 32, 64, 128, 256 (must divide 256).
- NUM_WORDS, derived localparam: 256/WORD_W. Not overridable.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request to snapshot `digest` and begin a transfer. Only acted on in IDLE.
- digest  in  256  digest from the message digest register.
- word_out  out  WORD_W  current output word.
- word_valid  out  1  `word_out` holds a valid word.
- word_ready  in  1  consumer accepts the word.
- word_last  out  1  high together with `word_valid` on the final word (index NUM_WORDS-1).
- busy  out  1  high in SEND.
- done  out  1  one-cycle pulse after the last word is accepted.
- overrun  out  1  sticky flag: `start` was seen while busy.

## Operation
- FSM has two states, IDLE and SEND.
- IDLE, with `start`=1:
  - load `snap` <= `digest`;
  - `idx` <= 0;
  - go to SEND.
- SEND:
  - `word_valid`=1.
  - `word_out` = `snap[255-idx*WORD_W -: WORD_W]`.
  - `word_last` = (`idx`==NUM_WORDS-1).
  - A beat occurs when `word_valid`&&`word_ready`. On a beat with `idx`<NUM_WORDS-1: `idx` increments.
  - On a beat with `idx`==NUM_WORDS-1: go to IDLE and assert `done` on the next cycle.
- `idx` width is clog2(NUM_WORDS), minimum 1 bit.
- When `word_valid` is high, `word_out` and `word_last` must stay stable until the beat.
- `start` while in SEND: the transfer in progress is unaffected and `overrun` is set to 1. This includes `start` in the same cycle as the last beat, which is ignored. `overrun` clears only on reset.
- `word_ready` while in IDLE is ignored.
- Changes on `digest` after the snapshot have no effect on the transfer in progress.
- Reset, including mid-transfer, has the following effect:
  - FSM goes to IDLE; `idx`=0; `snap`=0.
  - All outputs go to 0: `word_valid`, `word_last`, `busy`, `done`, `overrun`, `word_out`.
  - No partial words are emitted after reset.
- `word_out` is 0 whenever `word_valid`=0.

## Timing
- `start` sampled at edge N: `word_valid` and `busy` are high from cycle N+1 with word 0.
- With `word_ready` held at 1, one word is transferred per cycle. A full transfer takes NUM_WORDS cycles (8 for WORD_W=32).
- Last beat at edge M: in cycle M+1, `busy`=0, `word_valid`=0 and `done`=1. `done` returns to 0 in cycle M+2.
- The earliest next `start` is accepted at edge M+1, giving a minimum gap of one idle cycle between transfers.
- `word_ready` stalls of any length are allowed with no loss or duplication of words.
- All outputs are registered. There is no combinational path from `word_ready` to `word_valid`.

## Configuration
- DIGEST_SER_BYTESWAP_EN:
  - Defined: each output word is byte-reversed before it is driven. This gives little-endian byte order within the word; the order of the words themselves is unchanged. It only has an effect when WORD_W>=16. For WORD_W=8 the output is identical to undefined.
  - Undefined: words are driven big-endian, exactly as sliced from `snap`.

## Test plan
- Reset, then `start` with `digest`=SHA-256("abc") ba7816bf…f20015ad, WORD_W=32, `word_ready`=1:
  - eight words ba7816bf, 8f01cfea, 414140de, 5dae2223, b00361a3, 96177a9c, b410ff61, f20015ad on consecutive cycles;
  - `word_last` only on f20015ad;
  - `done` pulses once, one cycle after that beat.
- Same digest with `word_ready` toggled pseudo-randomly: identical word sequence, `word_out` stable during stalls, and no duplicated or dropped words.
- After `start`, change `digest` to e9b5b33f…f7e84b8f mid-transfer: the remaining words still come from the "abc" snapshot. A second `start` after `done` streams e9b5b33f first.
- Pulse `start` at word 3 and again coincident with the last beat: the current transfer completes normally, `overrun`=1 and stays 1, and no second transfer starts.
- Assert `reset` while `idx`=4 with `word_ready`=0: on the next cycle all outputs are 0 and the FSM is in IDLE. A new `start` begins again from word 0.
- Build with DIGEST_SER_BYTESWAP_EN defined, "abc" digest: the first word is bf1678ba and the last word is ad1500f2.
